// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//
// Write-back queue placed directly in front of the register file write port.
// Execution units push (address, data) results through a valid/ready
// handshake. Entries are held in an in-order circular FIFO and drained one
// per cycle into a registered waddr/wdata/wena stage. The drain pauses while
// wr_hold is high.
//
// Optional feature, selected by the macro WBQ_BYPASS_EN:
//   defined     - lk_addr is compared against every pending FIFO entry and
//                 against the output register; the youngest match drives
//                 lk_data and lk_hit is raised.
//   not defined - the lookup ports stay on the interface but are inert
//                 (lk_hit = 0, lk_data = 0) and no comparators are built.
//
// Parameters
//   DEPTH : FIFO entries (power of two, >= 2)
//   AW    : register address width
//   DW    : register data width
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : result available from the execution side
//   in_addr   : destination register of the result
//   in_data   : result value
//   in_ready  : queue can accept this cycle
//   wr_hold   : stall the drain; no entry leaves while high
//   waddr     : register file write address (registered)
//   wdata     : register file write data (registered)
//   wena      : register file write enable (registered)
//   lk_addr   : forwarding lookup address
//   lk_hit    : a pending write to lk_addr exists
//   lk_data   : data of the youngest pending write to lk_addr
//   empty     : FIFO empty and no write in the output register
//   count     : FIFO occupancy, not counting the output register
// -----------------------------------------------------------------------------
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [AW-1:0]              in_addr,
    input  logic [DW-1:0]              in_data,
    output logic                       in_ready,
    input  logic                       wr_hold,
    output logic [AW-1:0]              waddr,
    output logic [DW-1:0]              wdata,
    output logic                       wena,
    input  logic [AW-1:0]              lk_addr,
    output logic                       lk_hit,
    output logic [DW-1:0]              lk_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // FIFO storage: deliberately not reset, only pointers/count qualify it.
    logic [AW-1:0] mem_addr_q [DEPTH];
    logic [DW-1:0] mem_data_q [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          wena_q, wena_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic push;
    logic pop;

    // A full queue refuses input even when it pops in the same cycle, so
    // ready depends on registered occupancy only.
    assign in_ready = !rst && (count_q != FULL);
    assign push     = in_valid && in_ready;
    // Pop is based on registered occupancy, so an entry pushed into an empty
    // queue cannot leave in the same cycle.
    assign pop      = (count_q != '0) && !wr_hold;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        wena_d  = pop;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d  = rptr_q + PW'(1);
            waddr_d = mem_addr_q[rptr_q];
            wdata_d = mem_data_q[rptr_q];
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            wena_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            wena_q  <= wena_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wptr_q] <= in_addr;
            mem_data_q[wptr_q] <= in_data;
        end
    end

    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign wena  = wena_q;
    assign count = count_q;
    assign empty = (count_q == '0) && !wena_q;

`ifdef WBQ_BYPASS_EN
    logic          lk_hit_c;
    logic [DW-1:0] lk_data_c;
    logic [PW-1:0] lk_idx;

    // Scan oldest to youngest so that a later (younger) match overwrites an
    // earlier one; the output register is older than any FIFO entry.
    always_comb begin
        lk_hit_c  = 1'b0;
        lk_data_c = '0;
        lk_idx    = '0;
        if (wena_q && (waddr_q == lk_addr)) begin
            lk_hit_c  = 1'b1;
            lk_data_c = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = rptr_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_addr_q[lk_idx] == lk_addr)) begin
                lk_hit_c  = 1'b1;
                lk_data_c = mem_data_q[lk_idx];
            end
        end
    end

    assign lk_hit  = lk_hit_c;
    assign lk_data = lk_data_c;
`else
    logic unused_lk_addr;

    assign unused_lk_addr = ^lk_addr;
    assign lk_hit         = 1'b0;
    assign lk_data        = '0;
`endif

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue sitting directly upstream of the 32x64 register file write port. Execution units push (address, data) results through a valid/ready handshake; the block buffers them in an in-order FIFO and drains one entry per cycle onto the register file's `waddr`/`wdata`/`wena`, honouring a hold input. An optional forwarding lookup lets the operand-read stage see results that are still pending in the queue or are being written this cycle.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `AW`, 5: register address width.
- `DW`, 64: register data width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  result available from the execution side.
- `in_addr`  in  AW  destination register.
- `in_data`  in  DW  result value.
- `in_ready`  out  1  queue can accept; an entry is accepted when `in_valid && in_ready` at the clock edge.
- `wr_hold`  in  1  stall drain; no entry leaves the queue while this is high.
- `waddr`  out  AW  register file write address (registered).
- `wdata`  out  DW  register file write data (registered).
- `wena`  out  1  register file write enable (registered).
- `lk_addr`  in  AW  forwarding lookup address.
- `lk_hit`  out  1  a pending write to `lk_addr` exists.
- `lk_data`  out  DW  value of the youngest pending write to `lk_addr`.
- `empty`  out  1  FIFO empty and `wena` low.
- `count`  out  log2(DEPTH)+1  current FIFO occupancy, excluding the output register.

## Operation
- **Storage and pointers**
  - Circular FIFO of DEPTH {addr, data} entries.
  - Write and read pointers have log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter has log2(DEPTH)+1 bits.
- **Push and pop**
  - push = `in_valid && in_ready`.
  - pop = `count != 0 && !wr_hold`.
- **Ready**
  - `in_ready` = `!rst && count != DEPTH`, combinational from registered state.
  - A full queue does not accept, even in a cycle where it pops.
- **Output register**
  - Loads every cycle: `wena <= pop`.
  - On pop, `waddr`/`wdata` take the head entry; otherwise they hold their previous value.
- **Simultaneous push and pop**
  - Count is unchanged; both pointers advance.
  - Push into an empty queue: the entry is not popped in that same cycle.
- **Ordering and register 0**
  - Strict FIFO order; duplicate addresses are written in order, with no coalescing.
  - Address 0 is written like any other address.
- **Reset** (synchronous), all of the following in the same edge:
  - count=0 and both pointers=0; all pending entries are discarded, including mid-drain.
  - `wena`=0, `waddr`=0, `wdata`=0.
  - Resulting output values: `in_ready`=0 while `rst` is high and 1 on the first cycle after; `empty`=1; `lk_hit`=0.
  - FIFO storage contents are not reset.

## Timing
- Entry accepted at edge N:
  - earliest pop is at edge N+1;
  - `wena` is high during cycle N+1..N+2;
  - the register file captures the write at edge N+2.
- Drain throughput is one entry per cycle when `wr_hold`=0.
- `wr_hold` sampled high at edge N: `wena`=0 after edge N; the head entry is retained.
- Worst-case push-to-write latency with no hold is DEPTH+1 edges.
- `lk_hit`/`lk_data` are combinational from `lk_addr` and registered state; there is no register stage.

## Configuration
- Macro `WBQ_BYPASS_EN`.
- **Defined:** lookup compares `lk_addr` against every valid FIFO entry and against the output register when `wena`=1.
  - Priority, youngest first: newest FIFO entry, then older FIFO entries, then the output register.
  - `lk_hit`=1 on any match, and `lk_data` is the data of the highest-priority match.
  - An entry being pushed in the current cycle is not visible to the lookup.
- **Not defined:** `lk_addr` is ignored; `lk_hit`=0 and `lk_data`=0 constantly. The ports stay present, so the interface is unchanged; no comparators are built.

## Test plan
- **Reset values:** assert `rst` for 2 cycles, then release → `wena`=0, `waddr`=0, `wdata`=0, `count`=0, `empty`=1, `in_ready`=0 during reset and 1 after.
- **Single push:** push addr 5, data 0xDEAD_BEEF_0000_0001 at edge N with `wr_hold`=0 → `wena`=1, `waddr`=5, `wdata`=that value during cycle N+1..N+2 only; `empty`=1 after edge N+2.
- **Fill under hold:** `wr_hold`=1, push 4 entries to addrs 1..4 → `count`=4, `in_ready`=0; a fifth `in_valid` is not accepted. Release `wr_hold` → `wena` pulses on 4 consecutive cycles with addrs 1,2,3,4, and `in_ready`=1 one cycle after the first pop.
- **Wrap-around:** with hold toggling, push 10 entries, addrs 10..19 and data = addr → all 10 written in order with no loss or duplication; pointers wrap twice.
- **Forwarding (`WBQ_BYPASS_EN` defined):** hold=1, push addr 7/data 0x11, then addr 7/data 0x22; set `lk_addr`=7 → `lk_hit`=1, `lk_data`=0x22. Release hold → while the first write is in the output register, `lk_data` is still 0x22; after both drain, `lk_hit`=0. Without the macro → `lk_hit`=0 throughout.
- **Reset mid-drain:** hold=1, 3 entries queued; release hold and assert `rst` on the next edge → `wena`=0 after that edge, `count`=0, and no further writes appear.
